// File: rtl/command_decoder.sv
// ASCII hex command parser: turns "r AAAAAAAA\n" / "w AAAAAAAA DDDDDDDD\n" lines
// from an 8-bit stream into single Cs/We/Addr/Wdata bus transactions.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module command_decoder (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    S_axis_tvalid,
  input  logic [7:0]              S_axis_tdata,
  output logic                    S_axis_tready,
  output logic                    Cs,
  output logic                    We,
  output logic [`WORD_SIZE-1:0]   Addr,
  output logic [`WORD_SIZE-1:0]   Wdata,
  input  logic                    Ack,
  output logic                    Err
);

  localparam int unsigned WORD_W = `WORD_SIZE;
  localparam int unsigned DIGITS = WORD_W / 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_SEP1, S_ADDR, S_SEP2, S_DATA, S_EOL, S_BUS, S_ERROR
  } state_t;

  state_t              r_state, w_state_n;
  logic                r_we, w_we_n;
  logic [WORD_W-1:0]   r_addr, w_addr_n;
  logic [WORD_W-1:0]   r_wdata, w_wdata_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic                r_cs, w_cs_n;
  logic                r_err, w_err_n;

  logic                w_fire;
  logic [7:0]          w_byte;
  logic                w_is_hex, w_is_lf, w_is_cr, w_is_sp;
  logic                w_is_rd, w_is_wr, w_last_digit;
  logic [3:0]          w_nibble;

  assign w_byte        = S_axis_tdata;
  assign S_axis_tready = (r_state != S_BUS);
  assign w_fire        = S_axis_tvalid & S_axis_tready;
  assign w_is_lf       = (w_byte == 8'h0a);
  assign w_is_cr       = (w_byte == 8'h0d);
  assign w_is_sp       = (w_byte == 8'h20);
  assign w_is_rd       = (w_byte == 8'h72) || (w_byte == 8'h52);
  assign w_is_wr       = (w_byte == 8'h77) || (w_byte == 8'h57);
  assign w_last_digit  = (r_cnt == CNT_W'(DIGITS - 1));

  // ASCII hex digit to nibble
  always_comb begin
    w_is_hex = 1'b1;
    w_nibble = 4'h0;
    if (w_byte >= 8'h30 && w_byte <= 8'h39)      w_nibble = 4'(w_byte - 8'h30);
    else if (w_byte >= 8'h61 && w_byte <= 8'h66) w_nibble = 4'(w_byte - 8'h57);
    else if (w_byte >= 8'h41 && w_byte <= 8'h46) w_nibble = 4'(w_byte - 8'h37);
    else                                         w_is_hex = 1'b0;
  end

  // Next-state and registered-output decode; CR is transparent in every parse state
  always_comb begin
    w_state_n = r_state;
    w_we_n    = r_we;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_cnt_n   = r_cnt;
    w_err_n   = 1'b0;
    if (r_state == S_BUS) begin
      if (Ack) w_state_n = S_IDLE;
    end else if (w_fire && !w_is_cr) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_rd) begin
            w_state_n = S_SEP1;
            w_we_n    = 1'b0;
          end else if (w_is_wr) begin
            w_state_n = S_SEP1;
            w_we_n    = 1'b1;
          end else if (!w_is_lf) begin
            w_state_n = S_ERROR;
            w_err_n   = 1'b1;
          end
        end
        S_SEP1, S_SEP2: begin
          if (w_is_sp) begin
            w_state_n = (r_state == S_SEP1) ? S_ADDR : S_DATA;
            w_cnt_n   = '0;
          end else begin
            w_state_n = w_is_lf ? S_IDLE : S_ERROR;
            w_err_n   = 1'b1;
          end
        end
        S_ADDR, S_DATA: begin
          if (w_is_hex) begin
            w_cnt_n = r_cnt + CNT_W'(1);
            if (r_state == S_ADDR) begin
              w_addr_n = {r_addr[WORD_W-5:0], w_nibble};
              if (w_last_digit) w_state_n = r_we ? S_SEP2 : S_EOL;
            end else begin
              w_wdata_n = {r_wdata[WORD_W-5:0], w_nibble};
              if (w_last_digit) w_state_n = S_EOL;
            end
          end else begin
            w_state_n = w_is_lf ? S_IDLE : S_ERROR;
            w_err_n   = 1'b1;
          end
        end
        S_EOL: begin
          if (w_is_lf) begin
            w_state_n = S_BUS;
          end else begin
            w_state_n = S_ERROR;
            w_err_n   = 1'b1;
          end
        end
        S_ERROR: begin
          if (w_is_lf) w_state_n = S_IDLE;
        end
        default: ;
      endcase
    end
    w_cs_n = (w_state_n == S_BUS);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_cs    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_cnt   <= w_cnt_n;
      r_cs    <= w_cs_n;
      r_err   <= w_err_n;
    end
  end

  assign Cs    = r_cs;
  assign We    = r_we;
  assign Addr  = r_addr;
  assign Wdata = r_wdata;
  assign Err   = r_err;

endmodule

// File: tb/tb_command_decoder.sv
// Scoreboard bench for command_decoder: a line-level grammar model predicts
// one bus transaction or one Err pulse per non-empty line.
module tb_command_decoder;

  logic        Clk, Rst_n, S_axis_tvalid, S_axis_tready;
  logic [7:0]  S_axis_tdata;
  logic        Cs, We, Ack, Err;
  logic [31:0] Addr, Wdata;

  command_decoder dut (
    .Clk(Clk), .Rst_n(Rst_n), .S_axis_tvalid(S_axis_tvalid), .S_axis_tdata(S_axis_tdata),
    .S_axis_tready(S_axis_tready), .Cs(Cs), .We(We), .Addr(Addr), .Wdata(Wdata),
    .Ack(Ack), .Err(Err)
  );

  typedef struct packed {
    logic        is_err;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_mode = 0;   // 0: random delay, 1: held high, 2: never
  exp_t cur;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    return -1;
  endfunction

  function automatic bit hex_ok(input logic [7:0] l[$], input int s);
    for (int i = s; i < s + 8; i++) if (hexval(l[i]) < 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] hex_word(input logic [7:0] l[$], input int s);
    logic [31:0] v = 32'h0;
    for (int i = s; i < s + 8; i++) v = v * 16 + 32'(hexval(l[i]));
    return v;
  endfunction

  // Judge one complete line (CRs already removed) against the command grammar
  function automatic void eval_line(input logic [7:0] l[$]);
    exp_t e;
    int   sz = l.size();
    if (sz == 0) return;
    e = '0;
    e.is_err = 1'b1;
    if (sz == 10 && (l[0] == 8'h72 || l[0] == 8'h52) && l[1] == 8'h20 && hex_ok(l, 2)) begin
      e.is_err = 1'b0;
      e.addr   = hex_word(l, 2);
    end else if (sz == 19 && (l[0] == 8'h77 || l[0] == 8'h57) && l[1] == 8'h20 &&
                 hex_ok(l, 2) && l[10] == 8'h20 && hex_ok(l, 11)) begin
      e.is_err = 1'b0;
      e.we     = 1'b1;
      e.addr   = hex_word(l, 2);
      e.wdata  = hex_word(l, 11);
    end
    exp_q.push_back(e);
  endfunction

  function automatic void model(input logic [7:0] q[$]);
    logic [7:0] line[$];
    foreach (q[i]) begin
      if (q[i] == 8'h0d) continue;
      if (q[i] == 8'h0a) begin
        eval_line(line);
        line.delete();
      end else begin
        line.push_back(q[i]);
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge after the byte was consumed
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    S_axis_tvalid = 1'b1;
    S_axis_tdata  = b;
    while (!S_axis_tready && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 200) chk("tready_timeout", 32'(S_axis_tready), 32'd1);
    @(negedge Clk);
    S_axis_tvalid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge Clk);
  endtask

  task automatic send_q(input logic [7:0] q[$], input bit gaps);
    model(q);
    foreach (q[i]) send_byte(q[i], gaps);
  endtask

  task automatic send_str(input string s, input bit gaps);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_q(q, gaps);
  endtask

  function automatic logic [7:0] rand_hex_char();
    int n = $urandom_range(0, 15);
    if (n < 10) return 8'(48 + n);
    return 8'(($urandom_range(0, 1) ? 65 : 97) + n - 10);
  endfunction

  task automatic gen_chunk(output logic [7:0] q[$]);
    bit wr = 1'($urandom_range(0, 1));
    int pos;
    q.delete();
    if (wr) q.push_back($urandom_range(0, 1) ? 8'h77 : 8'h57);
    else    q.push_back($urandom_range(0, 1) ? 8'h72 : 8'h52);
    q.push_back(8'h20);
    repeat (8) q.push_back(rand_hex_char());
    if (wr) begin
      q.push_back(8'h20);
      repeat (8) q.push_back(rand_hex_char());
    end
    if ($urandom_range(0, 3) == 0) q.push_back(8'h0d);
    q.push_back(8'h0a);
    if ($urandom_range(0, 2) == 0) begin
      pos = $urandom_range(0, q.size() - 2);
      case ($urandom_range(0, 4))
        0: q[pos] = 8'($urandom_range(0, 255));
        1: q[pos] = 8'h0a;
        2: q.delete(pos);
        3: q.insert(pos, rand_hex_char());
        default: q.insert(pos, 8'h0d);
      endcase
    end
    if ($urandom_range(0, 9) == 0) q.push_front(8'h0a);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || Cs) && guard < 500) begin
      @(negedge Clk);
      guard++;
    end
    chk("drain_timeout", 32'(guard < 500), 32'd1);
  endtask

  // Bus responder
  initial begin
    int cs_cycles = 0;
    int ack_delay = 0;
    Ack = 1'b0;
    forever begin
      @(negedge Clk);
      if (ack_mode == 1) begin
        Ack = 1'b1;
      end else if (ack_mode == 2 || !Cs) begin
        Ack = 1'b0;
        cs_cycles = 0;
        ack_delay = $urandom_range(0, 3);
      end else begin
        Ack = (cs_cycles >= ack_delay);
        cs_cycles++;
      end
    end
  end

  // Monitor: every Err pulse and every Cs rising edge consumes one expectation
  initial begin
    logic prev_cs = 1'b0;
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n) begin
        if (Err) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_err: got Err=1 expected no event at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("err_kind", 32'(e.is_err), 32'd1);
          end
        end
        if (Cs && !prev_cs) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_cs: got Cs=1 Addr=%h expected no event at %0t", Addr, $time);
            cur = '0;
          end else begin
            e = exp_q.pop_front();
            cur = e;
            chk("txn_kind", 32'(e.is_err), 32'd0);
            chk("txn_we", 32'(We), 32'(e.we));
            chk("txn_addr", Addr, e.addr);
            if (e.we) chk("txn_wdata", Wdata, e.wdata);
          end
        end
        if (Cs) begin
          chk("tready_bus", 32'(S_axis_tready), 32'd0);
          chk("addr_stable", Addr, cur.addr);
        end else begin
          chk("tready_idle", 32'(S_axis_tready), 32'd1);
        end
      end
      prev_cs = Cs;
    end
  end

  initial begin
    logic [7:0] q[$];
    int guard;
    Rst_n = 1'b0;
    S_axis_tvalid = 1'b0;
    S_axis_tdata = 8'h00;
    #1;
    chk("rst_cs", 32'(Cs), 32'd0);
    chk("rst_we", 32'(We), 32'd0);
    chk("rst_addr", Addr, 32'h0);
    chk("rst_wdata", Wdata, 32'h0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_tready", 32'(S_axis_tready), 32'd1);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    send_str("r 0000abcd\n", 1'b0);
    send_str("W 1234ABcd 89abCDEF\r\n", 1'b0);
    send_str("r 12g45678\n", 1'b0);
    send_str("r 00000010\n", 1'b0);
    send_str("r 1234\n", 1'b0);
    send_str("r 123456789\n", 1'b0);
    send_str("\n\r\nR 00000020\n", 1'b0);
    wait_idle();

    ack_mode = 1;
    send_str("r 00000001\n", 1'b1);
    send_str("r 00000002\n", 1'b1);
    wait_idle();
    ack_mode = 0;

    // Asynchronous reset during an outstanding bus cycle
    ack_mode = 2;
    send_str("r 00000003\n", 1'b0);
    guard = 0;
    while (!Cs && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    chk("cs_before_reset", 32'(Cs), 32'd1);
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_cs", 32'(Cs), 32'd0);
    chk("arst_we", 32'(We), 32'd0);
    chk("arst_addr", Addr, 32'h0);
    chk("arst_wdata", Wdata, 32'h0);
    chk("arst_err", 32'(Err), 32'd0);
    chk("arst_tready", 32'(S_axis_tready), 32'd1);
    @(negedge Clk);
    Rst_n = 1'b1;
    ack_mode = 0;
    @(negedge Clk);
    send_str("r 00000004\n", 1'b0);
    wait_idle();

    for (int n = 0; n < 150; n++) begin
      gen_chunk(q);
      send_q(q, 1'($urandom_range(0, 1)));
      if (n == 75) ack_mode = 1;
      if (n == 100) ack_mode = 0;
    end
    wait_idle();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
